mem_wb_reg: RTL and testbench

MEM_WB_REG -- requirements
Module: mem_wb_reg

---
 rtl/mem_wb_reg.sv | 154 +++++++++++++++
 tb/tb_mem_wb_reg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg -- MEM/WB pipeline register with load-data extraction.
//
// Purpose:
//   Captures the MEM-stage instruction into the WB stage. The raw aligned
//   word from data memory is narrowed (byte / halfword / word, signed or
//   unsigned) in front of the register, so the WB stage sees a ready-to-use
//   operand. Misaligned loads are flagged and their register write is
//   suppressed. A retired-instruction counter is kept alongside.
//
// Pipeline control (one rule per rising edge, highest priority first):
//   flush : insert a bubble (all fields cleared, instret kept)
//   stall : every register, instret included, holds
//   else  : capture all fields; valid follows in_valid
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall, flush      pipeline hold / bubble insert
//   in_valid          MEM-stage instruction valid
//   PCInc_in          PC+4 of the MEM-stage instruction
//   ALUS_in           ALU result / memory address (bits [1:0] = byte offset)
//   datard_raw        raw aligned word from data memory
//   DMCtrl            load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//   RUDatawrSrc_in    writeback source (00 ALU, 01 load, 10 PC+4)
//   RUWr_in           register-file write enable
//   rd_in             destination register
//   PCInc/ALUS/datard registered writeback operands
//   RUDatawrSrc       registered writeback source select
//   RUWr              qualified register-file write enable
//   rd                registered destination
//   valid             WB-stage instruction valid
//   misalign          registered misaligned-load flag
//   instret           retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] PCInc_in,
    input  logic [31:0] ALUS_in,
    input  logic [31:0] datard_raw,
    input  logic [2:0]  DMCtrl,
    input  logic [1:0]  RUDatawrSrc_in,
    input  logic        RUWr_in,
    input  logic [4:0]  rd_in,
    output logic [31:0] PCInc,
    output logic [31:0] ALUS,
    output logic [31:0] datard,
    output logic [1:0]  RUDatawrSrc,
    output logic        RUWr,
    output logic [4:0]  rd,
    output logic        valid,
    output logic        misalign,
    output logic [31:0] instret
);

    localparam logic [2:0] DM_LB    = 3'b000;
    localparam logic [2:0] DM_LH    = 3'b001;
    localparam logic [2:0] DM_LW    = 3'b010;
    localparam logic [2:0] DM_LBU   = 3'b100;
    localparam logic [2:0] DM_LHU   = 3'b101;
    localparam logic [1:0] SRC_LOAD = 2'b01;

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] datard_next;
    logic        misalign_next;
    logic        ruwr_next;

    assign off = ALUS_in[1:0];

    // Byte/halfword lane selection. Halfword lane is chosen by off[1], so a
    // misaligned halfword still returns a deterministic value; it is never
    // written back because RUWr is suppressed for it.
    always_comb begin
        ld_byte = datard_raw[7:0];
        case (off)
            2'd0:    ld_byte = datard_raw[7:0];
            2'd1:    ld_byte = datard_raw[15:8];
            2'd2:    ld_byte = datard_raw[23:16];
            default: ld_byte = datard_raw[31:24];
        endcase
        ld_half = off[1] ? datard_raw[31:16] : datard_raw[15:0];
    end

    // Extension by load type; LW and reserved encodings pass the word through.
    always_comb begin
        datard_next = datard_raw;
        case (DMCtrl)
            DM_LB:   datard_next = {{24{ld_byte[7]}}, ld_byte};
            DM_LBU:  datard_next = {24'h0, ld_byte};
            DM_LH:   datard_next = {{16{ld_half[15]}}, ld_half};
            DM_LHU:  datard_next = {16'h0, ld_half};
            default: datard_next = datard_raw;
        endcase
    end

    // Only a valid instruction that actually writes back load data can be
    // misaligned; everything else reports aligned.
    always_comb begin
        misalign_next = 1'b0;
        if (in_valid && (RUDatawrSrc_in == SRC_LOAD)) begin
            case (DMCtrl)
                DM_LH, DM_LHU: misalign_next = off[0];
                DM_LW:         misalign_next = (off != 2'd0);
                default:       misalign_next = 1'b0;
            endcase
        end
    end

    // x0 is hard-wired zero, so a write to it is dropped here.
    assign ruwr_next = RUWr_in & in_valid & (rd_in != 5'd0) & ~misalign_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCInc       <= 32'h0;
            ALUS        <= 32'h0;
            datard      <= 32'h0;
            RUDatawrSrc <= 2'b00;
            RUWr        <= 1'b0;
            rd          <= 5'd0;
            valid       <= 1'b0;
            misalign    <= 1'b0;
            instret     <= 32'h0;
        end else if (flush) begin
            // Bubble wins over stall; the retired count is not touched.
            PCInc       <= 32'h0;
            ALUS        <= 32'h0;
            datard      <= 32'h0;
            RUDatawrSrc <= 2'b00;
            RUWr        <= 1'b0;
            rd          <= 5'd0;
            valid       <= 1'b0;
            misalign    <= 1'b0;
        end else if (!stall) begin
            PCInc       <= PCInc_in;
            ALUS        <= ALUS_in;
            datard      <= datard_next;
            RUDatawrSrc <= RUDatawrSrc_in;
            RUWr        <= ruwr_next;
            rd          <= rd_in;
            valid       <= in_valid;
            misalign    <= misalign_next;
            // Misaligned loads still count as retired.
            if (in_valid) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_reg.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_reg -- self-checking bench for mem_wb_reg.
// Directed steps followed by randomized traffic, all checked against a
// behavioural model of the MEM/WB register kept in this file.
// ---------------------------------------------------------------------------
module tb_mem_wb_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        stall, flush, in_valid, RUWr_in;
    logic [31:0] PCInc_in, ALUS_in, datard_raw;
    logic [2:0]  DMCtrl;
    logic [1:0]  RUDatawrSrc_in;
    logic [4:0]  rd_in;
    logic [31:0] PCInc, ALUS, datard, instret;
    logic [1:0]  RUDatawrSrc;
    logic        RUWr, valid, misalign;
    logic [4:0]  rd;

    mem_wb_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .PCInc_in(PCInc_in), .ALUS_in(ALUS_in),
        .datard_raw(datard_raw), .DMCtrl(DMCtrl),
        .RUDatawrSrc_in(RUDatawrSrc_in), .RUWr_in(RUWr_in), .rd_in(rd_in),
        .PCInc(PCInc), .ALUS(ALUS), .datard(datard),
        .RUDatawrSrc(RUDatawrSrc), .RUWr(RUWr), .rd(rd), .valid(valid),
        .misalign(misalign), .instret(instret)
    );

    // ---------------- scoreboard counters ----------------
    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model state ----------------
    logic [31:0] m_pcinc, m_alus, m_datard, m_instret;
    logic [1:0]  m_src;
    logic        m_ruwr, m_valid, m_mis;
    logic [4:0]  m_rd;
    logic        m_data_dc;   // captured datard is undefined (misaligned halfword)

    task automatic model_reset();
        m_pcinc = 0; m_alus = 0; m_datard = 0; m_instret = 0;
        m_src = 0; m_ruwr = 0; m_valid = 0; m_mis = 0; m_rd = 0;
        m_data_dc = 0;
    endtask

    // Value a load returns, computed by shifting the word down by the byte
    // offset and extending from the loaded width.
    function automatic logic [31:0] load_value(input logic [2:0] dm,
                                               input logic [31:0] raw,
                                               input logic [31:0] addr);
        int unsigned o;
        logic [31:0] w;
        o = addr % 4;
        case (dm)
            3'b000, 3'b100: begin
                w = (raw >> (8 * o)) & 32'hFF;
                if (dm == 3'b000 && w >= 32'h80) w = w - 32'h100;
            end
            3'b001, 3'b101: begin
                w = (raw >> (8 * (o - (o % 2)))) & 32'hFFFF;
                if (dm == 3'b001 && w >= 32'h8000) w = w - 32'h10000;
            end
            default: w = raw;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input logic v, input logic [1:0] src,
                                           input logic [2:0] dm,
                                           input logic [31:0] addr);
        int unsigned o;
        o = addr % 4;
        if (!v || src != 2'b01) return 1'b0;
        if (dm == 3'b001 || dm == 3'b101) return (o % 2) != 0;
        if (dm == 3'b010) return o != 0;
        return 1'b0;
    endfunction

    // Update the model for one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic mis;
        if (flush) begin
            m_pcinc = 0; m_alus = 0; m_datard = 0; m_src = 0;
            m_ruwr = 0; m_valid = 0; m_mis = 0; m_rd = 0; m_data_dc = 0;
        end else if (!stall) begin
            mis       = is_misaligned(in_valid, RUDatawrSrc_in, DMCtrl, ALUS_in);
            m_pcinc   = PCInc_in;
            m_alus    = ALUS_in;
            m_datard  = load_value(DMCtrl, datard_raw, ALUS_in);
            m_data_dc = (DMCtrl == 3'b001 || DMCtrl == 3'b101) && (ALUS_in % 2 != 0);
            m_src     = RUDatawrSrc_in;
            m_rd      = rd_in;
            m_valid   = in_valid;
            m_mis     = mis;
            m_ruwr    = RUWr_in && in_valid && rd_in != 0 && !mis;
            if (in_valid) m_instret = m_instret + 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".PCInc"},       PCInc,              m_pcinc);
        chk({tag, ".ALUS"},        ALUS,               m_alus);
        if (!m_data_dc) chk({tag, ".datard"}, datard,  m_datard);
        chk({tag, ".RUDatawrSrc"}, 32'(RUDatawrSrc),   32'(m_src));
        chk({tag, ".RUWr"},        32'(RUWr),          32'(m_ruwr));
        chk({tag, ".rd"},          32'(rd),            32'(m_rd));
        chk({tag, ".valid"},       32'(valid),         32'(m_valid));
        chk({tag, ".misalign"},    32'(misalign),      32'(m_mis));
        chk({tag, ".instret"},     instret,            m_instret);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".PCInc"},   PCInc, 0);
        chk({tag, ".ALUS"},    ALUS, 0);
        chk({tag, ".datard"},  datard, 0);
        chk({tag, ".src"},     32'(RUDatawrSrc), 0);
        chk({tag, ".RUWr"},    32'(RUWr), 0);
        chk({tag, ".rd"},      32'(rd), 0);
        chk({tag, ".valid"},   32'(valid), 0);
        chk({tag, ".misalign"},32'(misalign), 0);
        chk({tag, ".instret"}, instret, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] raw,
                         input logic [2:0] dm, input logic [1:0] src,
                         input logic we, input logic [4:0] dst);
        in_valid = v; PCInc_in = pc; ALUS_in = alu; datard_raw = raw;
        DMCtrl = dm; RUDatawrSrc_in = src; RUWr_in = we; rd_in = dst;
    endtask

    task automatic drive_random();
        drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    endtask

    // One rising edge: update model, wait for the edge, sample 1 time unit later.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset state, then release away from the edge.
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LB sign extension at offset 1.
        drive(1, 32'h100, 32'h1001, 32'h12AB80FF, 3'b000, 2'b01, 1, 5);
        tick("lb");
        chk("lb.datard_const", datard, 32'hFFFFFF80);
        chk("lb.ruwr_const", 32'(RUWr), 1);
        chk("lb.rd_const", 32'(rd), 5);
        chk("lb.valid_const", 32'(valid), 1);

        // LHU / LH upper halfword.
        drive(1, 32'h104, 32'h1002, 32'h12AB80FF, 3'b101, 2'b01, 1, 6);
        tick("lhu");
        chk("lhu.datard_const", datard, 32'h000012AB);
        drive(1, 32'h108, 32'h1002, 32'h80000000, 3'b001, 2'b01, 1, 6);
        tick("lh");
        chk("lh.datard_const", datard, 32'hFFFF8000);

        // LBU at offset 3 and LW aligned.
        drive(1, 32'h10C, 32'h2003, 32'hF1234567, 3'b100, 2'b01, 1, 7);
        tick("lbu3");
        chk("lbu3.datard_const", datard, 32'h000000F1);
        drive(1, 32'h110, 32'h2000, 32'hDEADBEEF, 3'b010, 2'b01, 1, 8);
        tick("lw");

        // Misaligned LW: flagged, write dropped, still retired.
        drive(1, 32'h114, 32'h1003, 32'h12AB80FF, 3'b010, 2'b01, 1, 9);
        tick("lw_mis");
        chk("lw_mis.misalign_const", 32'(misalign), 1);
        chk("lw_mis.ruwr_const", 32'(RUWr), 0);
        chk("lw_mis.instret_const", instret, 32'd6);

        // Stall holds an ALU result for three cycles while inputs churn.
        drive(1, 32'h118, 32'h55, 32'h0, 3'b010, 2'b00, 1, 3);
        tick("alu");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick("stall");
            chk("stall.ALUS_const", ALUS, 32'h55);
            chk("stall.rd_const", 32'(rd), 3);
        end
        flush = 1;
        tick("flush_stall");
        chk("flush_stall.valid_const", 32'(valid), 0);
        chk("flush_stall.instret_const", instret, 32'd7);
        // The bubble is not held by a continuing stall.
        flush = 0;
        tick("after_flush");
        stall = 0;

        // x0 is never written; JAL writes PC+4.
        drive(1, 32'h200, 32'h10, 32'h0, 3'b010, 2'b00, 1, 0);
        tick("x0");
        chk("x0.ruwr_const", 32'(RUWr), 0);
        drive(1, 32'h104, 32'h20, 32'h0, 3'b010, 2'b10, 1, 1);
        tick("jal");
        chk("jal.PCInc_const", PCInc, 32'h104);
        chk("jal.src_const", 32'(RUDatawrSrc), 2);
        chk("jal.ruwr_const", 32'(RUWr), 1);

        // Bubble: data captured, not valid, not written, not retired.
        drive(0, 32'h300, 32'h30, 32'h1234, 3'b010, 2'b00, 1, 4);
        tick("bubble");

        // Counter wrap.
        @(negedge clk);
        force dut.instret = 32'hFFFFFFFF;
        #1;
        release dut.instret;
        m_instret = 32'hFFFFFFFF;
        drive(1, 32'h400, 32'h40, 32'h0, 3'b010, 2'b00, 1, 2);
        tick("wrap");
        chk("wrap.instret_const", instret, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            drive_random();
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        // Reset asserted mid-stall between edges clears everything at once.
        stall = 1; flush = 1;
        drive_random();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0; flush = 0;
        drive(1, 32'h500, 32'h1002, 32'h0000ABCD, 3'b001, 2'b01, 1, 10);
        tick("post_reset");
        chk("post_reset.datard_const", datard, 32'h0);
        chk("post_reset.instret_const", instret, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
